// File: rtl/ap_mon_pkg.sv
// ap_mon_pkg: shared types, read-select codes and helpers for the ap_ctrl_chain
// performance monitor.
//   ap_state_e : per-channel module state (idle / active / stalled on back-pressure)
//   SEL_*      : statistic codes used on the rd_sel port
//   sat_inc    : increment that sticks at the all-ones value of a given width
package ap_mon_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StStall  = 2'd2
    } ap_state_e;

    localparam logic [2:0] SEL_TXN    = 3'd0;
    localparam logic [2:0] SEL_ACTIVE = 3'd1;
    localparam logic [2:0] SEL_STALL  = 3'd2;
    localparam logic [2:0] SEL_LAST   = 3'd3;
    localparam logic [2:0] SEL_MAX    = 3'd4;
    localparam logic [2:0] SEL_ITER   = 3'd5;
    localparam logic [2:0] SEL_STATE  = 3'd6;
    localparam logic [2:0] SEL_FLAGS  = 3'd7;

    // Saturating increment of the low w bits of v (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_val;
        max_val = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= max_val) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/ap_ctrl_chan_mon.sv
// ap_ctrl_chan_mon: one channel of the ap_ctrl_chain monitor. Tracks module state and
// outstanding transactions, and keeps saturating statistics plus sticky error flags.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start/ready/done/continue, i_iter   handshake and loop-iteration taps
//   i_freeze                hold statistics and flags (state/outstanding keep tracking)
//   i_clear                 synchronous zero of statistics and flags (wins over freeze)
//   o_txn_cnt .. o_iter_cnt statistics, o_state, o_outstanding, o_flags {proto, ovf, sat[5:0]}
module ap_ctrl_chan_mon
    import ap_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OUT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_ready,
    input  logic             i_done,
    input  logic             i_continue,
    input  logic             i_iter,
    input  logic             i_freeze,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_txn_cnt,
    output logic [CNT_W-1:0] o_active_cyc,
    output logic [CNT_W-1:0] o_stall_cyc,
    output logic [CNT_W-1:0] o_last_int,
    output logic [CNT_W-1:0] o_max_int,
    output logic [CNT_W-1:0] o_iter_cnt,
    output ap_state_e        o_state,
    output logic [OUT_W-1:0] o_outstanding,
    output logic [7:0]       o_flags
);

    ap_state_e        r_state, w_state_nxt;
    logic [OUT_W-1:0] r_out, w_out_nxt;
    logic [CNT_W-1:0] r_intv, w_intv_nxt;
    logic [CNT_W-1:0] r_txn, w_txn_nxt;
    logic [CNT_W-1:0] r_act, w_act_nxt;
    logic [CNT_W-1:0] r_stl, w_stl_nxt;
    logic [CNT_W-1:0] r_last, w_last_nxt;
    logic [CNT_W-1:0] r_max, w_max_nxt;
    logic [CNT_W-1:0] r_iter, w_iter_nxt;
    logic [5:0]       r_sat, w_sat_nxt;
    logic             r_err_proto, w_err_proto_nxt;
    logic             r_err_ovf, w_err_ovf_nxt;

    logic             w_accept, w_complete, w_stall;
    logic             w_out_zero, w_out_full;
    logic             w_cpl_ok, w_proto_ev, w_ovf_ev, w_busy;
    logic [CNT_W-1:0] w_intv_val;

    assign w_accept   = i_start & i_ready;
    assign w_complete = i_done & i_continue;
    assign w_stall    = i_done & ~i_continue;
    assign w_out_zero = (r_out == '0);
    assign w_out_full = (r_out == '1);
    assign w_cpl_ok   = w_complete & ~w_out_zero;
    assign w_proto_ev = w_complete & w_out_zero;
    assign w_ovf_ev   = w_accept & ~w_cpl_ok & w_out_full;
    // The start cycle seen in idle already counts as busy.
    assign w_busy     = (r_state != StIdle) | i_start;
    // Interval includes the completing cycle itself.
    assign w_intv_val = CNT_W'(sat_inc(64'(r_intv), CNT_W));

    // Outstanding transactions; simultaneous accept and valid complete cancel out.
    always_comb begin
        w_out_nxt = r_out;
        if (w_accept && !w_cpl_ok && !w_out_full) begin
            w_out_nxt = r_out + OUT_W'(1);
        end else if (w_cpl_ok && !w_accept) begin
            w_out_nxt = r_out - OUT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_nxt = StActive;
            end
            StActive, StStall: begin
                if (w_complete) begin
                    w_state_nxt = (w_out_nxt == '0 && !i_start) ? StIdle : StActive;
                end else if (w_stall) begin
                    w_state_nxt = StStall;
                end else begin
                    w_state_nxt = StActive;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Interval timer: loaded with 1 on the idle->active start cycle, restarted after
    // each valid complete so back-to-back completes measure 1.
    always_comb begin
        w_intv_nxt = r_intv;
        if (r_state == StIdle) begin
            w_intv_nxt = i_start ? CNT_W'(1) : '0;
        end else if (w_cpl_ok) begin
            w_intv_nxt = '0;
        end else begin
            w_intv_nxt = w_intv_val;
        end
    end

    always_comb begin
        w_txn_nxt       = r_txn;
        w_act_nxt       = r_act;
        w_stl_nxt       = r_stl;
        w_last_nxt      = r_last;
        w_max_nxt       = r_max;
        w_iter_nxt      = r_iter;
        w_sat_nxt       = r_sat;
        w_err_proto_nxt = r_err_proto;
        w_err_ovf_nxt   = r_err_ovf;
        if (i_clear) begin
            w_txn_nxt       = '0;
            w_act_nxt       = '0;
            w_stl_nxt       = '0;
            w_last_nxt      = '0;
            w_max_nxt       = '0;
            w_iter_nxt      = '0;
            w_sat_nxt       = '0;
            w_err_proto_nxt = 1'b0;
            w_err_ovf_nxt   = 1'b0;
        end else if (!i_freeze) begin
            if (w_cpl_ok) begin
                w_txn_nxt    = CNT_W'(sat_inc(64'(r_txn), CNT_W));
                w_sat_nxt[0] = r_sat[0] | (r_txn == '1);
                w_last_nxt   = w_intv_val;
                w_sat_nxt[3] = r_sat[3] | (r_intv == '1);
                if (w_intv_val > r_max) w_max_nxt = w_intv_val;
                w_sat_nxt[4] = r_sat[4] | (r_intv == '1);
            end
            if (w_busy) begin
                w_act_nxt    = CNT_W'(sat_inc(64'(r_act), CNT_W));
                w_sat_nxt[1] = r_sat[1] | (r_act == '1);
            end
            if (w_stall) begin
                w_stl_nxt    = CNT_W'(sat_inc(64'(r_stl), CNT_W));
                w_sat_nxt[2] = r_sat[2] | (r_stl == '1);
            end
            if (i_iter) begin
                w_iter_nxt   = CNT_W'(sat_inc(64'(r_iter), CNT_W));
                w_sat_nxt[5] = r_sat[5] | (r_iter == '1);
            end
            w_err_proto_nxt = r_err_proto | w_proto_ev;
            w_err_ovf_nxt   = r_err_ovf | w_ovf_ev;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_out       <= '0;
            r_intv      <= '0;
            r_txn       <= '0;
            r_act       <= '0;
            r_stl       <= '0;
            r_last      <= '0;
            r_max       <= '0;
            r_iter      <= '0;
            r_sat       <= '0;
            r_err_proto <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_intv      <= w_intv_nxt;
            r_txn       <= w_txn_nxt;
            r_act       <= w_act_nxt;
            r_stl       <= w_stl_nxt;
            r_last      <= w_last_nxt;
            r_max       <= w_max_nxt;
            r_iter      <= w_iter_nxt;
            r_sat       <= w_sat_nxt;
            r_err_proto <= w_err_proto_nxt;
            r_err_ovf   <= w_err_ovf_nxt;
        end
    end

    assign o_txn_cnt     = r_txn;
    assign o_active_cyc  = r_act;
    assign o_stall_cyc   = r_stl;
    assign o_last_int    = r_last;
    assign o_max_int     = r_max;
    assign o_iter_cnt    = r_iter;
    assign o_state       = r_state;
    assign o_outstanding = r_out;
    assign o_flags       = {r_err_proto, r_err_ovf, r_sat};

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: ap_ctrl_chain performance monitor for NUM_CH HLS modules.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_mon_start/ready/done/continue per-channel handshake taps (continue high for ap_ctrl_hs)
//   i_mon_iter                      per-channel loop iteration-end pulse
//   i_finish                        freeze statistics, sticky until i_clear
//   i_clear                         zero statistics, flags and the finish latch
//   i_rd_en, i_rd_ch, i_rd_sel      read request; o_rd_valid/o_rd_data one cycle later
// Statistic selects 6 and 7 are truncated to CNT_W, so CNT_W >= 8 keeps them complete.
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned OUT_W  = 4
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic [NUM_CH-1:0]                            i_mon_start,
    input  logic [NUM_CH-1:0]                            i_mon_ready,
    input  logic [NUM_CH-1:0]                            i_mon_done,
    input  logic [NUM_CH-1:0]                            i_mon_continue,
    input  logic [NUM_CH-1:0]                            i_mon_iter,
    input  logic                                         i_finish,
    input  logic                                         i_clear,
    input  logic                                         i_rd_en,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_rd_ch,
    input  logic [2:0]                                   i_rd_sel,
    output logic                                         o_rd_valid,
    output logic [CNT_W-1:0]                             o_rd_data
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             r_finish;
    logic             w_freeze;
    logic [CNT_W-1:0] w_ch_data [NUM_CH];
    logic [CNT_W-1:0] w_rd_mux;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;

    // Freeze already applies on the edge that samples finish.
    assign w_freeze = r_finish | i_finish;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_finish <= 1'b0;
        end else if (i_clear) begin
            r_finish <= 1'b0;
        end else if (i_finish) begin
            r_finish <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] w_txn, w_act, w_stl, w_last, w_max, w_iter, w_data;
        ap_state_e        w_state;
        logic [OUT_W-1:0] w_out;
        logic [7:0]       w_flags;

        ap_ctrl_chan_mon #(
            .CNT_W (CNT_W),
            .OUT_W (OUT_W)
        ) u_chan (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_start       (i_mon_start[g]),
            .i_ready       (i_mon_ready[g]),
            .i_done        (i_mon_done[g]),
            .i_continue    (i_mon_continue[g]),
            .i_iter        (i_mon_iter[g]),
            .i_freeze      (w_freeze),
            .i_clear       (i_clear),
            .o_txn_cnt     (w_txn),
            .o_active_cyc  (w_act),
            .o_stall_cyc   (w_stl),
            .o_last_int    (w_last),
            .o_max_int     (w_max),
            .o_iter_cnt    (w_iter),
            .o_state       (w_state),
            .o_outstanding (w_out),
            .o_flags       (w_flags)
        );

        always_comb begin
            w_data = '0;
            case (i_rd_sel)
                SEL_TXN:    w_data = w_txn;
                SEL_ACTIVE: w_data = w_act;
                SEL_STALL:  w_data = w_stl;
                SEL_LAST:   w_data = w_last;
                SEL_MAX:    w_data = w_max;
                SEL_ITER:   w_data = w_iter;
                SEL_STATE:  w_data = CNT_W'({w_state, w_out});
                SEL_FLAGS:  w_data = CNT_W'(w_flags);
                default:    w_data = '0;
            endcase
        end

        assign w_ch_data[g] = w_data;
    end

    // Unmatched channel numbers (>= NUM_CH) fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_rd_ch == CH_W'(c)) w_rd_mux = w_ch_data[c];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            r_rd_data  <= i_rd_en ? w_rd_mux : '0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Testbench for ap_ctrl_perf_monitor (NUM_CH=5, CNT_W=8, OUT_W=4).
module tb_ap_ctrl_perf_monitor;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OUT_W  = 4;

    typedef struct {
        int         ch;
        int         sel;
        logic [7:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] start, ready, done, cont, iter;
    logic              finish, clear, rd_en;
    logic [2:0]        rd_ch, rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_tab [NUM_CH][8];
    vec_t       vecs [$];

    always #5 clk = ~clk;

    ap_ctrl_perf_monitor #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .OUT_W  (OUT_W)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_mon_start    (start),
        .i_mon_ready    (ready),
        .i_mon_done     (done),
        .i_mon_continue (cont),
        .i_mon_iter     (iter),
        .i_finish       (finish),
        .i_clear        (clear),
        .i_rd_en        (rd_en),
        .i_rd_ch        (rd_ch),
        .i_rd_sel       (rd_sel),
        .o_rd_valid     (rd_valid),
        .o_rd_data      (rd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One-cycle read; other inputs keep their current values during the read cycle.
    task automatic rd_check(input string name, input int ch, input int sel, input logic [7:0] exp);
        rd_en  = 1'b1;
        rd_ch  = 3'(ch);
        rd_sel = 3'(sel);
        step();
        rd_en = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            n_err++;
            $display("FAIL %s: valid=%0b data=0x%0h, expected valid=1 data=0x%0h",
                     name, rd_valid, rd_data, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = '0;
        ready  = '0;
        done   = '0;
        cont   = '1;
        iter   = '0;
        finish = 1'b0;
        clear  = 1'b0;
        rd_en  = 1'b0;
        rd_ch  = '0;
        rd_sel = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset state: every statistic of every channel reads zero.
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 8; s++) begin
                rd_check($sformatf("reset ch%0d sel%0d", c, s), c, s, 8'h00);
            end
        end
        step();
        check("rd_valid idle", 32'(rd_valid), 32'd0);

        // ch0: single transaction, start cycle A, done four cycles later.
        start[0] = 1'b1; ready[0] = 1'b1;
        step();
        start[0] = 1'b0; ready[0] = 1'b0;
        repeat (3) step();
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;

        // ch1: done held with continue low for three cycles, then released.
        start[1] = 1'b1; ready[1] = 1'b1;
        step();
        start[1] = 1'b0; ready[1] = 1'b0;
        done[1] = 1'b1; cont[1] = 1'b0;
        step();
        step();
        rd_check("ch1 state during stall", 1, 6, 8'h21);
        cont[1] = 1'b1;
        step();
        done[1] = 1'b0;

        // ch2: three accepts on cycles 0..2, completes on cycles 20..22.
        start[2] = 1'b1; ready[2] = 1'b1;
        repeat (3) step();
        start[2] = 1'b0; ready[2] = 1'b0;
        rd_check("ch2 peak outstanding", 2, 6, 8'h13);
        repeat (16) step();
        done[2] = 1'b1;
        repeat (3) step();
        done[2] = 1'b0;

        // ch3: 257 iteration pulses saturate an 8-bit counter.
        iter[3] = 1'b1;
        repeat (257) step();
        iter[3] = 1'b0;

        // ch4: read coincident with an update returns the pre-edge value.
        iter[4] = 1'b1;
        rd_check("ch4 iter pre-edge", 4, 5, 8'h00);
        iter[4] = 1'b0;
        rd_check("ch4 iter post-edge", 4, 5, 8'h01);

        exp_tab[0] = '{8'h01, 8'h05, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00};
        exp_tab[1] = '{8'h01, 8'h05, 8'h03, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00};
        exp_tab[2] = '{8'h03, 8'h17, 8'h00, 8'h01, 8'h15, 8'h00, 8'h00, 8'h00};
        exp_tab[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h20};
        exp_tab[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 8; s++) begin
                vecs.push_back('{ch: c, sel: s, exp: exp_tab[c][s]});
            end
        end
        vecs.push_back('{ch: 5, sel: 0, exp: 8'h00});
        vecs.push_back('{ch: 7, sel: 5, exp: 8'h00});
        foreach (vecs[i]) begin
            rd_check($sformatf("stats ch%0d sel%0d", vecs[i].ch, vecs[i].sel),
                     vecs[i].ch, vecs[i].sel, vecs[i].exp);
        end

        // Clear zeroes statistics and flags.
        clear = 1'b1;
        step();
        clear = 1'b0;
        rd_check("clear ch3 iter", 3, 5, 8'h00);
        rd_check("clear ch3 flags", 3, 7, 8'h00);
        rd_check("clear ch2 max", 2, 4, 8'h00);

        // ch0: complete with nothing outstanding.
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        rd_check("proto flag", 0, 7, 8'h80);
        rd_check("proto txn", 0, 0, 8'h00);

        // Freeze, then five transactions; state still tracks.
        finish = 1'b1;
        step();
        finish = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start[0] = 1'b1; ready[0] = 1'b1;
            step();
            start[0] = 1'b0; ready[0] = 1'b0;
            if (i == 2) rd_check("frozen state tracks", 0, 6, 8'h11);
            done[0] = 1'b1;
            step();
            done[0] = 1'b0;
        end
        rd_check("frozen txn", 0, 0, 8'h00);
        rd_check("frozen active", 0, 1, 8'h00);
        rd_check("frozen last_int", 0, 3, 8'h00);
        rd_check("frozen flags", 0, 7, 8'h80);
        rd_check("idle after frozen txns", 0, 6, 8'h00);

        // Clear together with finish: clear wins, counting resumes.
        clear = 1'b1; finish = 1'b1;
        step();
        clear = 1'b0; finish = 1'b0;
        start[0] = 1'b1; ready[0] = 1'b1;
        step();
        start[0] = 1'b0; ready[0] = 1'b0;
        done[0] = 1'b1;
        step();
        done[0] = 1'b0;
        rd_check("unfrozen txn", 0, 0, 8'h01);
        rd_check("unfrozen last_int", 0, 3, 8'h02);
        rd_check("unfrozen flags", 0, 7, 8'h00);

        // Reset asserted while a read is in flight.
        rd_en = 1'b1; rd_ch = 3'd0; rd_sel = 3'd0;
        step();
        check("rd_valid before reset", 32'(rd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rd_valid at reset", 32'(rd_valid), 32'd0);
        check("rd_data at reset", 32'(rd_data), 32'd0);
        rd_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        rd_check("txn after reset", 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
# ap_ctrl_perf_monitor

Synthesizable, parametrised monitor for the ap_ctrl_chain handshakes of up to NUM_CH HLS modules and their pipelined loops. Per channel, it tracks the module state and outstanding transactions, and counts completions, active cycles, back-pressure stalls, completion intervals and loop iterations. All counters are read through a registered select port. It sits beside the accelerator top and taps the same ap_start/ap_ready/ap_done/ap_continue and loop-iteration signals the simulation monitors sample, so the same statistics are available on hardware.

## Interface
- NUM_CH, 4, monitored channels (1..16)
- CNT_W, 32, width of every statistic counter
- OUT_W, 4, width of the per-channel outstanding-transaction counter
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mon_start / mon_ready / mon_done / mon_continue  in  NUM_CH each  per-channel ap_ctrl_chain taps; tie continue high for ap_ctrl_hs modules
- mon_iter  in  NUM_CH  loop iteration-end pulse (iter_end_enable && !iter_end_block)
- finish  in  1  freezes all statistic counters; sticky until clear
- clear  in  1  synchronous zero of counters, flags and finish latch
- rd_en  in  1  read request
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel to read
- rd_sel  in  3  statistic select, see Operation
- rd_valid  out  1  read data valid
- rd_data  out  CNT_W  read data

## Operation
- Per-channel events: accept = start&&ready; complete = done&&continue; stall = done&&!continue.
- Outstanding counter: +1 on accept, −1 on complete, unchanged when both occur.
  - Accept at all-ones: counter holds and sticky err_ovf is set.
  - Complete at 0: counter holds, err_proto is set, and the completion is not counted.
- State machine per channel (IDLE, ACTIVE, STALL):
  - IDLE→ACTIVE on start.
  - ACTIVE→STALL on stall.
  - ACTIVE/STALL→IDLE on complete when the outstanding count after the update is 0 and start is low.
  - Otherwise ACTIVE/STALL→ACTIVE on complete.
  - STALL holds while stall persists.
- Statistics (saturate at all-ones; saturation sets sticky sat bit i for rd_sel i):
  - sel 0, txn_cnt: valid completes.
  - sel 1, active_cyc: cycles in ACTIVE or STALL.
  - sel 2, stall_cyc: cycles with stall.
  - sel 3, last_int: interval from IDLE→ACTIVE entry, or from the previous complete, to this complete, inclusive of both edges' cycles (start then done on the next cycle gives 2).
  - sel 4, max_int: maximum last_int since clear.
  - sel 5, iter_cnt: mon_iter pulses.
  - sel 6: {state[1:0], outstanding} zero-extended.
  - sel 7: {err_proto, err_ovf, sat[5:0]} zero-extended.
- finish latched high: sel 0–5 and the flags stop updating. State and outstanding keep tracking.
- clear: zeroes sel 0–5, flags and the finish latch. State and outstanding are unchanged. clear dominates finish in the same cycle.

## Timing
- Reset: all counters 0, state IDLE, outstanding 0, flags 0, finish latch 0, rd_valid 0, rd_data 0.
- Events sampled at the rising edge; statistics visible on the following cycle.
- Read: rd_en at edge N gives rd_valid=1 and rd_data at N+1 (1-cycle latency). Back-to-back reads are allowed, one per cycle. rd_valid is low whenever rd_en was low.
- A read coincident with an update or clear returns the pre-edge value.
- rd_ch ≥ NUM_CH returns 0 with rd_valid=1.
- Reset assertion mid-transaction aborts everything immediately; no partial interval is recorded.

## Structure
- Package ap_mon_pkg holds:
  - the state enum (IDLE=0, ACTIVE=1, STALL=2)
  - the SEL_* constants 0..7
  - a saturating-increment function
- Sub-module ap_ctrl_chan_mon holds one channel's FSM, outstanding counter, statistics and flags. It is instantiated NUM_CH times by generate.
- The top holds the finish latch, the read mux and the output register.

## Test plan
- Single transaction: ch0 start=1 at cycle 10, ready=1 at 10, done=1 at 14, continue=1 → txn_cnt=1, active_cyc=5, last_int=5, max_int=5, state IDLE, outstanding 0.
- Back-pressure: ch1 done held with continue=0 for 3 cycles, then continue=1 → stall_cyc=3, state STALL during the hold, txn_cnt=1.
- Pipelined overlap: ch2 three accepts on consecutive cycles, completes 20 cycles later on consecutive cycles → outstanding peaks at 3, txn_cnt=3, last_int=1, state IDLE after the third complete.
- Saturation with CNT_W=4: 17 mon_iter pulses on ch3 → iter_cnt=15, sel 7 bit 5 set. Then clear → iter_cnt=0, bit cleared.
- Protocol error and freeze:
  - complete on ch0 with outstanding 0 → err_proto=1, txn_cnt unchanged.
  - finish=1, then 5 further transactions → counters frozen, sel 6 still tracks state.
- Read path: rd_en with rd_ch=NUM_CH → rd_valid=1, rd_data=0 one cycle later. Reset asserted mid-read → rd_valid=0 at once.
